// File: rtl/sram_burst_master.sv
// Fabric-side burst initiator for the configurable-width SRAM port.
// Sequences one element access per cycle and tracks read latency to return rdata.
module sram_burst_master #(
    parameter int unsigned SRAM_LAT = 2,
    parameter int unsigned OUT_REG  = 0,
    parameter int unsigned LEN_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [2:0]        i_req_conf,
    input  logic [13:0]       i_req_addr,
    input  logic [LEN_W-1:0]  i_req_len,
    input  logic              i_wdata_valid,
    output logic              o_wdata_ready,
    input  logic [31:0]       i_wdata,
    output logic              o_rdata_valid,
    output logic [31:0]       o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_csb,
    output logic              o_web,
    output logic [13:0]       o_addr,
    output logic [2:0]        o_conf,
    output logic              o_out_reg,
    output logic [31:0]       o_d_fabric_in,
    input  logic [31:0]       i_d_fabric_out
);
    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CONF_W = 3;
    localparam int unsigned PIPE_W = SRAM_LAT + OUT_REG + 1;
    localparam logic [CONF_W-1:0] CONF_MAX = CONF_W'(5);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    // Element index wraps within the 2^(14-conf) elements of the macro.
    function automatic logic [ADDR_W-1:0] addr_mask(input logic [CONF_W-1:0] c);
        return {ADDR_W{1'b1}} >> c;
    endfunction

    // Keeps only the low 2^conf bits of a data word.
    function automatic logic [DATA_W-1:0] data_mask(input logic [CONF_W-1:0] c);
        logic [DATA_W-1:0] m;
        m = '1;
        if (c < CONF_MAX) m = (DATA_W'(1) << (6'd1 << c)) - DATA_W'(1);
        return m;
    endfunction

    state_t              r_state;
    logic [CONF_W-1:0]   r_conf;
    logic [ADDR_W-1:0]   r_cur;
    logic [LEN_W-1:0]    r_beats;
    logic [PIPE_W-1:0]   r_pipe;
    logic                r_req_ready;
    logic                r_wdata_ready;
    logic                r_rdata_valid;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;
    logic                r_err;
    logic                r_csb;
    logic                r_web;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_din;

    logic                w_beat;
    logic                w_issue_rd;
    logic                w_last;
    logic [ADDR_W-1:0]   w_cur_next;
    logic [DATA_W-1:0]   w_dmask;

    assign w_beat     = (r_state == S_WRITE) && r_wdata_ready && i_wdata_valid;
    assign w_issue_rd = (r_state == S_READ);
    assign w_last     = (r_beats == '0);
    assign w_cur_next = (r_cur + ADDR_W'(1)) & addr_mask(r_conf);
    assign w_dmask    = data_mask(r_conf);

    assign o_req_ready   = r_req_ready;
    assign o_wdata_ready = r_wdata_ready;
    assign o_rdata_valid = r_rdata_valid;
    assign o_rdata       = r_rdata;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_csb         = r_csb;
    assign o_web         = r_web;
    assign o_addr        = r_addr;
    assign o_conf        = r_conf;
    assign o_out_reg     = (OUT_REG != 0);
    assign o_d_fabric_in = r_din;

    // Burst sequencer; read-tracking pipe bit k is set k cycles after the issue cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_conf        <= '0;
            r_cur         <= '0;
            r_beats       <= '0;
            r_pipe        <= '0;
            r_req_ready   <= 1'b1;
            r_wdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rdata       <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_csb         <= 1'b1;
            r_web         <= 1'b1;
            r_addr        <= '0;
            r_din         <= '0;
        end else begin
            r_done        <= 1'b0;
            r_err         <= 1'b0;
            r_pipe        <= (r_pipe << 1) | PIPE_W'(w_issue_rd);
            r_rdata_valid <= r_pipe[PIPE_W-1];
            r_rdata       <= r_pipe[PIPE_W-1] ? (i_d_fabric_out & w_dmask) : '0;

            case (r_state)
                S_IDLE: begin
                    r_csb <= 1'b1;
                    r_web <= 1'b1;
                    if (i_req_valid && r_req_ready) begin
                        if (i_req_conf > CONF_MAX) begin
                            r_err <= 1'b1;
                        end else begin
                            r_conf        <= i_req_conf;
                            r_cur         <= i_req_addr & addr_mask(i_req_conf);
                            r_beats       <= i_req_len;
                            r_req_ready   <= 1'b0;
                            r_wdata_ready <= i_req_write;
                            r_state       <= i_req_write ? S_WRITE : S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_beat) begin
                        r_csb <= 1'b0;
                        r_web <= 1'b0;
                        r_addr <= r_cur;
                        r_din <= i_wdata & w_dmask;
                        r_cur <= w_cur_next;
                        if (w_last) begin
                            r_wdata_ready <= 1'b0;
                            r_state       <= S_DRAIN;
                        end else begin
                            r_beats <= r_beats - LEN_W'(1);
                        end
                    end else begin
                        r_csb <= 1'b1;
                        r_web <= 1'b1;
                    end
                end
                S_READ: begin
                    r_csb  <= 1'b0;
                    r_web  <= 1'b1;
                    r_addr <= r_cur;
                    r_cur  <= w_cur_next;
                    if (w_last) r_state <= S_DRAIN;
                    else        r_beats <= r_beats - LEN_W'(1);
                end
                S_DRAIN: begin
                    r_csb <= 1'b1;
                    r_web <= 1'b1;
                    if (r_pipe == '0) begin
                        r_done      <= 1'b1;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master: two instances (OUT_REG=0 and 1) share
// stimulus and a bit-addressed SRAM model with per-instance read latency.
module tb_sram_burst_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_write, wdata_valid;
    logic [2:0]  req_conf;
    logic [13:0] req_addr;
    logic [7:0]  req_len;
    logic [31:0] wdata;

    logic [1:0]  req_ready, wdata_ready, rdata_valid, done, err, csb, web, out_reg;
    logic [13:0] addr [2];
    logic [2:0]  conf [2];
    logic [31:0] rdata [2];
    logic [31:0] din [2];
    logic [31:0] dout [2];

    sram_burst_master #(.SRAM_LAT(2), .OUT_REG(0), .LEN_W(8)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[0]),
        .i_req_write(req_write), .i_req_conf(req_conf), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready[0]), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid[0]), .o_rdata(rdata[0]), .o_done(done[0]), .o_err(err[0]),
        .o_csb(csb[0]), .o_web(web[0]), .o_addr(addr[0]), .o_conf(conf[0]), .o_out_reg(out_reg[0]),
        .o_d_fabric_in(din[0]), .i_d_fabric_out(dout[0])
    );

    sram_burst_master #(.SRAM_LAT(2), .OUT_REG(1), .LEN_W(8)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready[1]),
        .i_req_write(req_write), .i_req_conf(req_conf), .i_req_addr(req_addr), .i_req_len(req_len),
        .i_wdata_valid(wdata_valid), .o_wdata_ready(wdata_ready[1]), .i_wdata(wdata),
        .o_rdata_valid(rdata_valid[1]), .o_rdata(rdata[1]), .o_done(done[1]), .o_err(err[1]),
        .o_csb(csb[1]), .o_web(web[1]), .o_addr(addr[1]), .o_conf(conf[1]), .o_out_reg(out_reg[1]),
        .o_d_fabric_in(din[1]), .i_d_fabric_out(dout[1])
    );

    // SRAM model: element of 2^conf bits at bit offset addr*2^conf; upper read bits carry junk.
    logic        mem [16384];
    logic [31:0] p0 [2];
    logic [31:0] p1 [3];
    assign dout[0] = p0[1];
    assign dout[1] = p1[2];

    function automatic logic [31:0] mem_rd(input logic [13:0] a, input logic [2:0] c);
        logic [31:0] r;
        int w;
        r = 32'h5A5A5A5A;
        w = 1 << c;
        for (int b = 0; b < w; b++) r[b] = mem[(int'(a) * w + b) % 16384];
        return r;
    endfunction

    always @(posedge clk) begin
        p0[0] <= mem_rd(addr[0], conf[0]);
        p0[1] <= p0[0];
        p1[0] <= mem_rd(addr[1], conf[1]);
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        if (!csb[0] && !web[0])
            for (int b = 0; b < (1 << conf[0]); b++)
                mem[(int'(addr[0]) * (1 << conf[0]) + b) % 16384] <= din[0][b];
    end

    // Monitor logs port activity of instance 0 and read returns of both.
    typedef struct { int cyc; logic [13:0] a; logic we_n; logic [31:0] d; logic [2:0] c; } cs_t;
    typedef struct { int cyc; logic [31:0] d; } rd_t;
    cs_t q_cs [$];
    rd_t q_rd0 [$];
    rd_t q_rd1 [$];
    int  cyc = 0;
    int  n_done = 0;
    int  n_err = 0;
    logic        tr_csb [2048];
    logic [13:0] tr_addr [2048];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < 2048) begin
            tr_csb[cyc]  <= csb[0];
            tr_addr[cyc] <= addr[0];
        end
        if (!csb[0]) q_cs.push_back('{cyc, addr[0], web[0], din[0], conf[0]});
        if (rdata_valid[0]) q_rd0.push_back('{cyc, rdata[0]});
        if (rdata_valid[1]) q_rd1.push_back('{cyc, rdata[1]});
        if (done[0]) n_done <= n_done + 1;
        if (err[0])  n_err  <= n_err + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;
    int b_cs, b_rd0, b_rd1, b_done, b_err;
    logic [31:0] wbuf [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        b_cs   = q_cs.size();
        b_rd0  = q_rd0.size();
        b_rd1  = q_rd1.size();
        b_done = n_done;
        b_err  = n_err;
    endtask

    task automatic send_req(input logic w, input logic [2:0] c, input logic [13:0] a, input logic [7:0] l);
        int t = 0;
        @(negedge clk);
        while (!req_ready[0] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready[0]) check("req_ready_timeout", 32'(req_ready[0]), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_conf  = c;
        req_addr  = a;
        req_len   = l;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic feed(input int n, input int gap_at, input int gap_len);
        int i = 0;
        int g = 0;
        int t = 0;
        while (i < n && t < 100) begin
            @(negedge clk);
            t++;
            if (i == gap_at && g < gap_len) begin
                wdata_valid = 1'b0;
                g++;
            end else begin
                wdata_valid = 1'b1;
                wdata = wbuf[i];
                if (wdata_ready[0]) i++;
            end
        end
        if (i < n) check("wdata_timeout", 32'(i), 32'(n));
        @(negedge clk);
        wdata_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (n_done == b_done && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (n_done == b_done) check({tag, "_done_timeout"}, 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int k;
        int t;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_conf = '0;
        req_addr = '0; req_len = '0; wdata_valid = 1'b0; wdata = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_req_ready", 32'(req_ready[0]), 32'd1);
        check("rst_csb", 32'(csb[0]), 32'd1);
        check("rst_web", 32'(web[0]), 32'd1);
        check("rst_addr", 32'(addr[0]), 32'd0);
        check("rst_conf", 32'(conf[0]), 32'd0);
        check("rst_din", din[0], 32'd0);
        check("rst_wdata_ready", 32'(wdata_ready[0]), 32'd0);
        check("rst_rdata_valid", 32'(rdata_valid[0]), 32'd0);
        check("rst_rdata", rdata[0], 32'd0);
        check("rst_done_err", 32'({done[0], err[0]}), 32'd0);
        check("out_reg0", 32'(out_reg[0]), 32'd0);
        check("out_reg1", 32'(out_reg[1]), 32'd1);

        // Write conf=5 addr=3 len=3, continuous data
        mark();
        wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
        send_req(1'b1, 3'd5, 14'h003, 8'd3);
        feed(4, 99, 0);
        wait_done("wr5");
        check("wr5_beats", 32'(q_cs.size() - b_cs), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wr5_addr%0d", i), 32'(q_cs[b_cs+i].a), 32'(3 + i));
            check($sformatf("wr5_din%0d", i), q_cs[b_cs+i].d, 32'hA0 + 32'(i));
            check($sformatf("wr5_web%0d", i), 32'(q_cs[b_cs+i].we_n), 32'd0);
        end
        check("wr5_contig", 32'(q_cs[b_cs+3].cyc - q_cs[b_cs].cyc), 32'd3);
        check("wr5_conf", 32'(q_cs[b_cs].c), 32'd5);
        check("wr5_done", 32'(n_done - b_done), 32'd1);

        // Read back, latency 3 (OUT_REG=0) and 4 (OUT_REG=1)
        mark();
        send_req(1'b0, 3'd5, 14'h003, 8'd3);
        wait_done("rd5");
        check("rd5_issues", 32'(q_cs.size() - b_cs), 32'd4);
        check("rd5_web", 32'(q_cs[b_cs].we_n), 32'd1);
        check("rd5_contig", 32'(q_cs[b_cs+3].cyc - q_cs[b_cs].cyc), 32'd3);
        check("rd5_cnt0", 32'(q_rd0.size() - b_rd0), 32'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("rd5_data%0d", i), q_rd0[b_rd0+i].d, 32'hA0 + 32'(i));
        check("rd5_lat0", 32'(q_rd0[b_rd0].cyc - q_cs[b_cs].cyc), 32'd3);
        check("rd5_cnt1", 32'(q_rd1.size() - b_rd1), 32'd4);
        check("rd5_lat1", 32'(q_rd1[b_rd1].cyc - q_cs[b_cs].cyc), 32'd4);
        check("rd5_data1_last", q_rd1[b_rd1+3].d, 32'hA3);
        check("rd5_done", 32'(n_done - b_done), 32'd1);

        // Write conf=3 at top element, wraps to 0, data masked to 8 bits
        mark();
        wbuf[0] = 32'h1FF; wbuf[1] = 32'h2AB;
        send_req(1'b1, 3'd3, 14'h7FF, 8'd1);
        feed(2, 99, 0);
        wait_done("wr3");
        check("wr3_addr0", 32'(q_cs[b_cs].a), 32'h7FF);
        check("wr3_addr1", 32'(q_cs[b_cs+1].a), 32'h000);
        check("wr3_din0", q_cs[b_cs].d, 32'hFF);
        check("wr3_din1", q_cs[b_cs+1].d, 32'hAB);

        // Read it back: upper junk from the macro must be zeroed
        mark();
        send_req(1'b0, 3'd3, 14'h7FF, 8'd1);
        wait_done("rd3");
        check("rd3_cnt", 32'(q_rd0.size() - b_rd0), 32'd2);
        check("rd3_data0", q_rd0[b_rd0].d, 32'hFF);
        check("rd3_data1", q_rd0[b_rd0+1].d, 32'hAB);

        // Single-beat (len=0) read of a 4-bit element
        mark();
        send_req(1'b0, 3'd2, 14'h000, 8'd0);
        wait_done("rd2");
        check("rd2_issues", 32'(q_cs.size() - b_cs), 32'd1);
        check("rd2_cnt", 32'(q_rd0.size() - b_rd0), 32'd1);
        check("rd2_data", q_rd0[b_rd0].d, 32'hB);

        // Write with a two-cycle wdata_valid gap after the first beat
        mark();
        wbuf[0] = 32'h11; wbuf[1] = 32'h22; wbuf[2] = 32'h33;
        send_req(1'b1, 3'd5, 14'h010, 8'd2);
        feed(3, 1, 2);
        wait_done("gap");
        check("gap_beats", 32'(q_cs.size() - b_cs), 32'd3);
        check("gap_delta01", 32'(q_cs[b_cs+1].cyc - q_cs[b_cs].cyc), 32'd3);
        check("gap_delta12", 32'(q_cs[b_cs+2].cyc - q_cs[b_cs+1].cyc), 32'd1);
        check("gap_csb1", 32'(tr_csb[q_cs[b_cs].cyc + 1]), 32'd1);
        check("gap_csb2", 32'(tr_csb[q_cs[b_cs].cyc + 2]), 32'd1);
        check("gap_addr_hold", 32'(tr_addr[q_cs[b_cs].cyc + 2]), 32'h010);
        check("gap_addr2", 32'(q_cs[b_cs+2].a), 32'h012);
        check("gap_din2", q_cs[b_cs+2].d, 32'h33);

        // Illegal conf: err pulse, no access, ready stays up
        mark();
        send_req(1'b0, 3'd6, 14'h000, 8'd0);
        repeat (5) @(negedge clk);
        check("bad_err", 32'(n_err - b_err), 32'd1);
        check("bad_no_cs", 32'(q_cs.size() - b_cs), 32'd0);
        check("bad_no_done", 32'(n_done - b_done), 32'd0);
        check("bad_ready", 32'(req_ready[0]), 32'd1);

        // Reset after the fifth issue of a 16-beat read
        mark();
        send_req(1'b0, 3'd5, 14'h000, 8'd15);
        k = 0;
        t = 0;
        while (k < 5 && t < 50) begin
            @(negedge clk);
            t++;
            if (!csb[0]) k++;
        end
        check("abort_reached5", 32'(k), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("abort_csb", 32'(csb[0]), 32'd1);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("abort_issues", 32'(q_cs.size() - b_cs), 32'd5);
        check("abort_rd0", 32'(q_rd0.size() - b_rd0), 32'd2);
        check("abort_rd1", 32'(q_rd1.size() - b_rd1), 32'd1);
        check("abort_no_done", 32'(n_done - b_done), 32'd0);
        check("abort_ready", 32'(req_ready[0]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
